// File: rtl/maior_menor_stream_pkg.sv
// Shared definitions for the streaming max/min extractor: state encoding and default sizes.
package maior_menor_stream_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/maior_menor_stream_if.sv
// Burst-in / result-out handshake bundle for maior_menor_stream.
interface maior_menor_stream_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) ();
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             out_empty;
    logic [WIDTH-1:0] out_max;
    logic [WIDTH-1:0] out_min;
    logic [LEN_W-1:0] out_max_idx;
    logic [LEN_W-1:0] out_min_idx;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_empty, out_max, out_min, out_max_idx, out_min_idx
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_empty, out_max, out_min, out_max_idx, out_min_idx
    );
endinterface

// File: rtl/maior_menor_cmp.sv
// Magnitude comparator, signed or unsigned by parameter; gt = a>b, lt = a<b.
module maior_menor_cmp #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt
);
    generate
        if (SIGNED) begin : g_signed
            assign gt = $signed(a) > $signed(b);
            assign lt = $signed(a) < $signed(b);
        end else begin : g_unsigned
            assign gt = a > b;
            assign lt = a < b;
        end
    endgenerate
endmodule

// File: rtl/maior_menor_stream.sv
// Collects a burst of len samples and reports max, min and the first index of each.
module maior_menor_stream
    import maior_menor_stream_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LEN_W  = DEF_LEN_W,
    parameter bit SIGNED = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    maior_menor_stream_if.slave   bus
);
    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [WIDTH-1:0] max_q, min_q;
    logic [LEN_W-1:0] max_idx_q, min_idx_q;
    logic             empty_q;

    logic accept, last;
    logic new_max, new_min;
    logic max_lt_unused, min_gt_unused;

    maior_menor_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_max (
        .a  (bus.in_data),
        .b  (max_q),
        .gt (new_max),
        .lt (max_lt_unused)
    );

    maior_menor_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_min (
        .a  (bus.in_data),
        .b  (min_q),
        .gt (min_gt_unused),
        .lt (new_min)
    );

    assign accept = (state_q == S_COLLECT) && bus.in_valid;
    assign last   = accept && (cnt_q == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = (bus.len == '0) ? S_DONE : S_COLLECT;
            end
            S_COLLECT: begin
                if (last) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Results are only overwritten by a new burst, so they stay readable after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            len_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            empty_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.len == '0) begin
                            empty_q   <= 1'b1;
                            max_q     <= '0;
                            min_q     <= '0;
                            max_idx_q <= '0;
                            min_idx_q <= '0;
                        end else begin
                            len_q <= bus.len;
                            cnt_q <= '0;
                        end
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (cnt_q == '0) begin
                            max_q     <= bus.in_data;
                            min_q     <= bus.in_data;
                            max_idx_q <= '0;
                            min_idx_q <= '0;
                        end else begin
                            if (new_max) begin
                                max_q     <= bus.in_data;
                                max_idx_q <= cnt_q;
                            end
                            if (new_min) begin
                                min_q     <= bus.in_data;
                                min_idx_q <= cnt_q;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) empty_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == S_COLLECT);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.out_empty   = empty_q;
    assign bus.out_max     = max_q;
    assign bus.out_min     = min_q;
    assign bus.out_max_idx = max_idx_q;
    assign bus.out_min_idx = min_idx_q;
endmodule
